iiitb_4bbc_checker: RTL and testbench
=====================================

// Module: iiitb_4bbc_checker
// PURPOSE
//  Observes the output of the 4-bit up/down binary counter and its direction/reset controls.
//  Predicts each next Count value, locks onto a valid sequence and flags deviations.
//  Counts errors and reports wrap events.
//  Sits beside the counter as an on-chip sequence monitor (self-test / BIST observer).
// PARAMETERS
//  WIDTH        4  width of the observed Count bus
//  ERR_W        8  width of the saturating error counter
//  LOCK_CYCLES  2  consecutive correct samples required to enter LOCKED (1..15)
// PORTS
//  Clk        in   1      single clock; all state updates on rising edge
//  reset      in   1      asynchronous, active-low reset of this block
//  en         in   1      sample enable; 0 = hold all state, no pulses
//  Count      in   WIDTH  observed counter output
//  UpOrDown   in   1      observed direction: 1 = up, 0 = down
//  ctr_reset  in   1      observed counter reset (active-high, counter's own)
//  clr_err    in   1      synchronous clear of err_count (and sticky regs)
//  locked     out  1      1 while in LOCKED state
//  mismatch   out  1      1-cycle pulse: LOCKED sample differed from prediction
//  wrap_up    out  1      1-cycle pulse: accepted step from all-ones to 0 going up
//  wrap_dn    out  1      1-cycle pulse: accepted step from 0 to all-ones going down
//  expected   out  WIDTH  prediction for the current sample
//  err_count  out  ERR_W  saturating count of mismatches
// BEHAVIOUR
//  - Reset (reset=0, async): state=UNLOCKED, all outputs 0, prev regs 0, match counter 0.
//  - Per-sample history: prev_cnt, prev_dir and prev_rst are registered on every en=1 edge.
//  - Prediction (combinational from history):
//    - prev_rst=1 -> expected = 0.
//    - Otherwise expected = prev_cnt + 1 if prev_dir=1, else prev_cnt - 1.
//    - Arithmetic is mod 2^WIDTH.
//    - The one-sample lag matches the counter's registered output.
//  - UNLOCKED: first en=1 sample loads history only -> ACQUIRE, match counter 0.
//  - ACQUIRE:
//    - Count==expected: match counter +1; reaching LOCK_CYCLES -> LOCKED.
//    - Count!=expected: match counter 0; no error is counted.
//  - LOCKED:
//    - Count==expected: stay LOCKED.
//    - Count!=expected: mismatch=1 for one cycle, err_count+1 (saturates at all-ones).
//      State -> ACQUIRE with match counter 0. History reloads from the observed sample (resync).
//  - Wrap pulses are only in LOCKED, on a matching sample, with prev_rst=0.
//    - wrap_up: prev_cnt=all-ones, dir up. wrap_dn: prev_cnt=0, dir down.
//  - mismatch, wrap_up and wrap_dn are registered. Each is high the cycle after its sample edge, for exactly one cycle.
//  - en=0: state, history and counters hold; pulses are 0.
//  - Direction change while LOCKED is legal. The prediction uses the direction in effect at the previous sample.
//  - ctr_reset held high: expected stays 0; a Count of 0 keeps lock.
//  - clr_err with a simultaneous mismatch: clear wins, err_count=0.
//  - reset asserted mid-operation: immediate return to the reset values. No pulse is emitted.
// CONFIGURATION
//  BBC_CHK_STICKY_EN defined:
//    - Adds outputs first_exp[WIDTH-1:0], first_got[WIDTH-1:0] and first_vld.
//    - These capture expected/Count of the first mismatch since reset or clr_err.
//    - Later mismatches do not overwrite them. clr_err and reset zero all three.
//  BBC_CHK_STICKY_EN undefined: the ports and registers are absent. All other behaviour is identical.
// TESTING
//  - Reset, en=1, up-count 0,1,2,3 -> locked=1 after sample 3 (LOCK_CYCLES=2).
//    Also expected=4 at the next sample, err_count=0.
//  - Locked up-count 14,15,0 -> wrap_up pulses once at 15->0.
//    Then switch UpOrDown=0 at 2 -> 1,0,15 with no mismatch; wrap_dn pulses once at 0->15.
//  - Locked, inject Count=9 where 5 is expected -> mismatch 1 cycle, err_count=1, locked=0.
//    Correct 10,11 follow -> locked=1 again.
//    With BBC_CHK_STICKY_EN: first_exp=5, first_got=9, first_vld=1.
//  - Locked at 7, ctr_reset=1 for 3 samples with Count=0 -> locked stays 1.
//    Release, up 1,2 -> no mismatch.
//  - Force 300 mismatches (ERR_W=8) -> err_count saturates at 255.
//    clr_err together with a mismatch -> err_count=0.
//  - en=0 for 5 cycles with Count toggling randomly -> state and err_count unchanged.
//    Async reset pulse mid-LOCKED -> all outputs 0 immediately.

Source files
------------

// File: rtl/iiitb_4bbc_checker.sv
// iiitb_4bbc_checker: sequence monitor for a 4-bit up/down counter; predicts, locks, counts errors, flags wraps.
// Optional BBC_CHK_STICKY_EN adds first_exp/first_got/first_vld capture of the first mismatch.
module iiitb_4bbc_checker #(
  parameter int WIDTH       = 4,
  parameter int ERR_W       = 8,
  parameter int LOCK_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] Count,
  input  logic             UpOrDown,
  input  logic             ctr_reset,
  input  logic             clr_err,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_count
`ifdef BBC_CHK_STICKY_EN
  ,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got,
  output logic             first_vld
`endif
);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
  state_t           state;
  logic [WIDTH-1:0] prev_cnt, pred;
  logic             prev_dir, prev_rst, hit;
  logic [3:0]       mcnt;
  assign pred     = prev_rst ? '0 : prev_dir ? prev_cnt + WIDTH'(1) : prev_cnt - WIDTH'(1);
  // no history exists yet while unlocked, so the prediction is shown as 0
  assign expected = (state == UNLOCKED) ? '0 : pred;
  assign hit      = Count == pred;
  assign locked   = state == LOCKED;
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state     <= UNLOCKED;
      prev_cnt  <= '0;
      prev_dir  <= 1'b0;
      prev_rst  <= 1'b0;
      mcnt      <= '0;
      mismatch  <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_dn   <= 1'b0;
      err_count <= '0;
`ifdef BBC_CHK_STICKY_EN
      first_exp <= '0;
      first_got <= '0;
      first_vld <= 1'b0;
`endif
    end else begin
      mismatch <= 1'b0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      if (en) begin
        prev_cnt <= Count;
        prev_dir <= UpOrDown;
        prev_rst <= ctr_reset;
        case (state)
          UNLOCKED: begin
            state <= ACQUIRE;
            mcnt  <= '0;
          end
          ACQUIRE: begin
            mcnt  <= (hit && mcnt + 4'd1 != 4'(LOCK_CYCLES)) ? mcnt + 4'd1 : '0;
            state <= (hit && mcnt + 4'd1 == 4'(LOCK_CYCLES)) ? LOCKED : ACQUIRE;
          end
          default: begin
            if (hit) begin
              wrap_up <= !prev_rst && prev_dir && prev_cnt == '1;
              wrap_dn <= !prev_rst && !prev_dir && prev_cnt == '0;
            end else begin
              mismatch  <= 1'b1;
              state     <= ACQUIRE;
              mcnt      <= '0;
              err_count <= (err_count == '1) ? err_count : err_count + ERR_W'(1);
`ifdef BBC_CHK_STICKY_EN
              if (!first_vld) begin
                first_exp <= pred;
                first_got <= Count;
                first_vld <= 1'b1;
              end
`endif
            end
          end
        endcase
      end
      if (clr_err) begin
        err_count <= '0;
`ifdef BBC_CHK_STICKY_EN
        first_exp <= '0;
        first_got <= '0;
        first_vld <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_iiitb_4bbc_checker.sv
// tb_iiitb_4bbc_checker: directed scenarios plus randomized counter traffic against a behavioural model.
module tb_iiitb_4bbc_checker;
  localparam int LC = 2;
  logic       Clk = 1'b0, reset = 1'b1, en = 1'b0, UpOrDown = 1'b0, ctr_reset = 1'b0, clr_err = 1'b0;
  logic [3:0] Count = '0, expected;
  logic [7:0] err_count;
  logic       locked, mismatch, wrap_up, wrap_dn;
`ifdef BBC_CHK_STICKY_EN
  logic [3:0] first_exp, first_got;
  logic       first_vld;
`endif
  int checks = 0, errors = 0;

  iiitb_4bbc_checker #(.WIDTH(4), .ERR_W(8), .LOCK_CYCLES(LC)) dut (
    .Clk(Clk), .reset(reset), .en(en), .Count(Count), .UpOrDown(UpOrDown),
    .ctr_reset(ctr_reset), .clr_err(clr_err), .locked(locked), .mismatch(mismatch),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn), .expected(expected), .err_count(err_count)
`ifdef BBC_CHK_STICKY_EN
    , .first_exp(first_exp), .first_got(first_got), .first_vld(first_vld)
`endif
  );

  always #5 Clk = ~Clk;

  // Model: last accepted sample, whether we are trusting the sequence, streak of good samples.
  bit m_hv, m_pd, m_pr, m_lock, m_mis, m_wu, m_wd, m_fv;
  int m_pc, m_streak, m_err, m_fe, m_fg;

  function automatic int predict();
    return m_pr ? 0 : (m_pc + (m_pd ? 1 : -1) + 16) % 16;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  initial forever begin
    @(posedge Clk or negedge reset);
    if (!reset) begin
      {m_hv, m_pd, m_pr, m_lock, m_mis, m_wu, m_wd, m_fv} = '0;
      {m_pc, m_streak, m_err, m_fe, m_fg} = '0;
    end else begin
      m_mis = 0; m_wu = 0; m_wd = 0;
      if (en) begin
        int p;
        bit ok;
        p  = predict();
        ok = int'(Count) == p;
        if (!m_hv) begin
          m_hv = 1; m_streak = 0;
        end else if (m_lock) begin
          if (ok) begin
            m_wu = !m_pr && m_pd && m_pc == 15;
            m_wd = !m_pr && !m_pd && m_pc == 0;
          end else begin
            m_mis = 1; m_lock = 0; m_streak = 0;
            m_err = (m_err < 255) ? m_err + 1 : 255;
            if (!m_fv) begin m_fv = 1; m_fe = p; m_fg = int'(Count); end
          end
        end else begin
          m_streak = ok ? m_streak + 1 : 0;
          if (m_streak >= LC) begin m_lock = 1; m_streak = 0; end
        end
        m_pc = int'(Count); m_pd = UpOrDown; m_pr = ctr_reset;
      end
      if (clr_err) begin m_err = 0; m_fv = 0; m_fe = 0; m_fg = 0; end
    end
  end

  initial forever begin
    @(negedge Clk);
    chk("locked", locked, m_lock);
    chk("mismatch", mismatch, m_mis);
    chk("wrap_up", wrap_up, m_wu);
    chk("wrap_dn", wrap_dn, m_wd);
    chk("expected", expected, m_hv ? predict() : 0);
    chk("err_count", err_count, m_err);
`ifdef BBC_CHK_STICKY_EN
    chk("first_vld", first_vld, m_fv);
    chk("first_exp", first_exp, m_fe);
    chk("first_got", first_got, m_fg);
`endif
  end

  task automatic step(input bit e, input int c, input bit d, input bit r = 0, input bit cl = 0);
    en = e; Count = 4'(c); UpOrDown = d; ctr_reset = r; clr_err = cl;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int c, ctr, v;
    bit d, r, e, cl;
    #1 reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1, i, 1);
    chk("pin_lock_after_3", locked, 1);
    chk("pin_expected_4", expected, 4);
    chk("pin_err0", err_count, 0);
    for (int i = 4; i <= 15; i++) step(1, i, 1);
    step(1, 0, 1);
    chk("pin_wrap_up", wrap_up, 1);
    step(1, 1, 1);
    chk("pin_wrap_up_once", wrap_up, 0);
    step(1, 2, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 15, 0);
    chk("pin_wrap_dn", wrap_dn, 1);
    chk("pin_no_mismatch_dirchg", err_count, 0);
    step(1, 14, 1);
    for (int i = 15; i <= 20; i++) step(1, i % 16, 1);
    step(1, 9, 1);
    chk("pin_inject_mismatch", mismatch, 1);
    chk("pin_inject_err1", err_count, 1);
    chk("pin_inject_unlocked", locked, 0);
`ifdef BBC_CHK_STICKY_EN
    chk("pin_first_exp", first_exp, 5);
    chk("pin_first_got", first_got, 9);
    chk("pin_first_vld", first_vld, 1);
`endif
    step(1, 10, 1);
    step(1, 11, 1);
    chk("pin_relock", locked, 1);
    step(1, 12, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1);
    step(1, 0, 1, 0);
    step(1, 1, 1);
    step(1, 2, 1);
    chk("pin_ctr_reset_lock", locked, 1);
    chk("pin_ctr_reset_err", err_count, 1);
    c = 2;
    for (int i = 0; i < 300; i++) begin
      c = (c + 8) & 15; step(1, c, 1);
      c = (c + 1) & 15; step(1, c, 1);
      c = (c + 1) & 15; step(1, c, 1);
    end
    chk("pin_saturate", err_count, 255);
    c = (c + 8) & 15;
    step(1, c, 1, 0, 1);
    chk("pin_clr_wins_mis", mismatch, 1);
    chk("pin_clr_wins_err", err_count, 0);
    c = (c + 1) & 15; step(1, c, 1);
    c = (c + 1) & 15; step(1, c, 1);
    for (int i = 0; i < 5; i++) step(0, $urandom_range(0, 15), $urandom_range(0, 1));
    chk("pin_en0_lock", locked, 1);
    chk("pin_en0_err", err_count, 0);
    c = (c + 1) & 15; step(1, c, 1);
    chk("pin_en0_resume", mismatch, 0);
    ctr = (c + 1) & 15; d = 1; r = 0;
    for (int i = 0; i < 3000; i++) begin
      e  = $urandom_range(0, 7) != 0;
      cl = e && $urandom_range(0, 49) == 0;
      if (e) begin
        if ($urandom_range(0, 7) == 0) d = ~d;
        r = $urandom_range(0, 9) == 0;
        v = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15)) : ctr;
        step(1, v, d, r, cl);
        ctr = r ? 0 : (v + (d ? 1 : 15)) % 16;
      end else step(0, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1), 0);
    end
    for (int i = 3; i <= 6; i++) step(1, i, 1);
    chk("pin_pre_reset_lock", locked, 1);
    #3 reset = 1'b0;
    #1;
    chk("pin_async_locked", locked, 0);
    chk("pin_async_err", err_count, 0);
    chk("pin_async_expected", expected, 0);
    chk("pin_async_mismatch", mismatch, 0);
    @(posedge Clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1, i, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
